// File: rtl/fetch_pc_unit.sv
// Fetch PC register and instruction-memory request FSM answering the hazard controller.
// Optional misaligned-target detection is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_pc_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_pc_i,
    input  logic [1:0]        pcsrc_i,
    input  logic [ADDR_W-1:0] branch_alu_i,
    input  logic [ADDR_W-1:0] branch_pc_jump_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              fsm_pcsrc_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_instr_o,
    output logic              if_valid_o,
    output logic              misalign_o
);

    localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] load_target;

    function automatic logic [ADDR_W-1:0] select_target(
        input logic [1:0]        src,
        input logic [ADDR_W-1:0] cur_pc,
        input logic [ADDR_W-1:0] alu_tgt,
        input logic [ADDR_W-1:0] jmp_tgt
    );
        logic [ADDR_W-1:0] t;
        case (src)
            2'b00:   t = cur_pc + ADDR_W'(4);
            2'b01:   t = alu_tgt & ~ADDR_W'(1);
            2'b10:   t = jmp_tgt;
            default: t = cur_pc;
        endcase
        return t;
    endfunction

    function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
        return t & ~ADDR_W'(3);
`else
        return t;
`endif
    endfunction

    assign raw_target  = select_target(pcsrc_i, pc, branch_alu_i, branch_pc_jump_i);
    assign load_target = align_target(raw_target);
    // The fetch address is the PC itself, so it stays stable for the whole REQ phase.
    assign imem_addr_o = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            imem_req_o  <= 1'b0;
            fsm_pcsrc_o <= 1'b0;
            if_valid_o  <= 1'b0;
            if_instr_o  <= NOP_INSTR;
            if_pc_o     <= RESET_PC;
        end else begin
            case (state)
                BOOT: begin
                    state      <= REQ;
                    imem_req_o <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        state      <= WAIT;
                        imem_req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state       <= READY;
                        if_instr_o  <= imem_rdata_i;
                        if_pc_o     <= pc;
                        if_valid_o  <= 1'b1;
                        fsm_pcsrc_o <= 1'b1;
                    end
                end
                READY: begin
                    if (en_pc_i) begin
                        state       <= REQ;
                        pc          <= load_target;
                        if_valid_o  <= 1'b0;
                        fsm_pcsrc_o <= 1'b0;
                        imem_req_o  <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Sticky: once a bad target is seen it stays flagged until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_o <= 1'b0;
        end else if (state == READY && en_pc_i && raw_target[1:0] != 2'b00) begin
            misalign_o <= 1'b1;
        end
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side responder to the hazard controller: owns the PC register and the instruction-memory request FSM.
- Applies the hazard controller's PC-enable and PC-source decisions.
- Reports back, via fsm_pcsrc_o, when fetch is ready to accept a PC update.
- Sits between the hazard control unit, instruction memory and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en_pc_i  in  1  PC update enable from hazard controller (already gated with fsm_pcsrc_o upstream)
pcsrc_i  in  2  PC source: 00 next_pc (pc+4), 01 branch_alu, 10 branch_pc_jump, 11 nop (hold)
branch_alu_i  in  ADDR_W  target computed by ALU (jalr / reg-relative)
branch_pc_jump_i  in  ADDR_W  PC-relative branch/jump target
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  ADDR_W  fetch address
imem_gnt_i  in  1  request accepted by memory
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  DATA_W  read data
fsm_pcsrc_o  out  1  fetch ready: instruction held, PC may be updated this cycle
if_pc_o  out  ADDR_W  PC of the held instruction
if_instr_o  out  DATA_W  held instruction
if_valid_o  out  1  if_instr_o is valid
misalign_o  out  1  sticky misaligned-target flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - imem_req_o=0, fsm_pcsrc_o=0, if_valid_o=0, if_instr_o=32'h0000_0013 (nop), if_pc_o=RESET_PC, misalign_o=0.
- States:
  - BOOT: one cycle after reset release, no request; then REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc (held stable until grant). If imem_gnt_i=1 then WAIT, else stay.
  - WAIT: imem_req_o=0. If imem_rvalid_i=1, latch if_instr_o=imem_rdata_i, if_pc_o=pc, if_valid_o=1, then READY. A response in the same cycle as the grant is not accepted; rvalid is sampled only in WAIT.
  - READY: fsm_pcsrc_o=1; instruction held stable. If en_pc_i=0, stay (stall; outputs frozen). If en_pc_i=1, load pc per pcsrc_i, set if_valid_o=0, then REQ.
- PC update rules:
  - next_pc: pc+4, mod 2^ADDR_W (wrap from 32'hFFFF_FFFC to 0).
  - branch_alu: branch_alu_i with bit0 cleared.
  - branch_pc_jump: branch_pc_jump_i.
  - nop: pc unchanged, but the same address is re-fetched.
- Outputs:
  - fsm_pcsrc_o is a registered state decode: 1 only in READY.
  - if_valid_o is 0 in BOOT, REQ and WAIT.
- Latency: en_pc_i in READY produces imem_req_o next cycle. With zero-wait memory (gnt on first REQ cycle, rvalid next cycle), READY recurs 3 cycles after the update.
- Bounds and corner cases:
  - en_pc_i asserted outside READY is ignored.
  - imem_rvalid_i in REQ, BOOT or READY is ignored.
  - Reset mid-transaction aborts immediately; the outstanding response is never latched.

Optional Feature:
- FETCH_MISALIGN_CHK_EN defined:
  - On update, a target with bits[1:0]!=0 sets misalign_o=1 (sticky until reset).
  - The PC is loaded with bits[1:0] cleared.
- Undefined: misalign_o is constant 0 and targets are loaded unchanged (except the bit0 clear on branch_alu).

Test Plan:
- Reset release, memory gives gnt on first REQ cycle and rvalid=1, rdata=32'h00500093 the next cycle -> imem_addr_o=0 in cycle 2; READY with if_instr_o=32'h00500093, if_pc_o=0, fsm_pcsrc_o=1 in cycle 4.
- In READY, en_pc_i=1, pcsrc_i=00 -> next imem_addr_o=4; if_valid_o drops to 0 until rvalid.
- In READY, en_pc_i=1, pcsrc_i=01, branch_alu_i=32'h0000_0105 -> imem_addr_o=32'h0000_0104.
- In READY, en_pc_i=0 for 5 cycles -> if_instr_o, if_pc_o and fsm_pcsrc_o held; no imem_req_o.
- In REQ, gnt withheld 3 cycles -> imem_req_o=1 and imem_addr_o stable; en_pc_i=1 pulsed meanwhile is ignored.
- pc=32'hFFFF_FFFC, update with next_pc -> imem_addr_o=0. With FETCH_MISALIGN_CHK_EN, branch_pc_jump_i=32'h0000_0202 -> addr 32'h0000_0200 and misalign_o=1, held until rst_n=0.
